// File: rtl/cipher_pkg.sv
// Shared definitions for the ciphertext receive path: receiver FSM states and
// the default frame length.
package cipher_pkg;

    localparam int MSG_SIZE_DEFAULT = 512;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RECV = 1'b1
    } rx_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous first-word-fall-through FIFO. A write while full is accepted
// only if a read retires the head in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_wr;
    logic             do_rd;

    // The extra pointer bit tells full apart from empty when the indices match.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_rd   = rd_en && !empty;
    assign do_wr   = wr_en && (!full || do_rd);
    assign rd_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/ciphertext_receiver.sv
// Deserialises framed ciphertext bits MSB-first into bytes, queues them in a
// byte FIFO and reports frame completion, framing faults and FIFO overflow.
module ciphertext_receiver
    import cipher_pkg::*;
#(
    parameter int MSG_SIZE   = MSG_SIZE_DEFAULT,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                        iClk,
    input  logic                        iRst,
    input  logic                        iSerial_in,
    input  logic                        iSerial_start,
    input  logic                        iSerial_end,
    output logic [7:0]                  oByte,
    output logic                        oByte_valid,
    input  logic                        iByte_ready,
    output logic                        oFrame_done,
    output logic                        oFrame_error,
    output logic                        oOverflow,
    output logic [$clog2(MSG_SIZE):0]   oBit_count
);

    localparam int CW = $clog2(MSG_SIZE) + 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(MSG_SIZE - 1);
    localparam logic [CW-1:0] MSG_BITS = CW'(MSG_SIZE);

    rx_state_t     state, state_nxt;
    logic [CW-1:0] bit_count, bit_count_nxt, count_inc;
    logic [7:0]    shift_q, shift_nxt, shift_inc;
    logic          push, pop, done_nxt, error_nxt;
    logic          fifo_full, fifo_empty;

    assign count_inc = bit_count + 1'b1;
    assign shift_inc = {shift_q[6:0], iSerial_in};

    always_comb begin
        state_nxt     = state;
        bit_count_nxt = bit_count;
        shift_nxt     = shift_q;
        push          = 1'b0;
        done_nxt      = 1'b0;
        error_nxt     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (iSerial_start) begin
                    bit_count_nxt = CW'(1);
                    shift_nxt     = {7'b0, iSerial_in};
                    if (iSerial_end) begin
                        error_nxt = 1'b1;
                        shift_nxt = '0;
                    end else begin
                        state_nxt = ST_RECV;
                    end
                end
            end
            ST_RECV: begin
                if (iSerial_start) begin
                    // A fresh start mid-frame abandons the partial byte and
                    // counts the current bit as bit 0 of the new frame.
                    error_nxt     = 1'b1;
                    bit_count_nxt = CW'(1);
                    shift_nxt     = {7'b0, iSerial_in};
                    if (iSerial_end) begin
                        state_nxt = ST_IDLE;
                        shift_nxt = '0;
                    end
                end else begin
                    bit_count_nxt = count_inc;
                    shift_nxt     = shift_inc;
                    push          = (count_inc[2:0] == 3'b000);
                    if (iSerial_end) begin
                        state_nxt = ST_IDLE;
                        if (bit_count == LAST_BIT) begin
                            done_nxt = 1'b1;
                        end else begin
                            error_nxt = 1'b1;
                            shift_nxt = '0;
                        end
                    end else if (count_inc == MSG_BITS) begin
                        error_nxt = 1'b1;
                        state_nxt = ST_IDLE;
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Byte handshake: oByte_valid means the head byte on oByte is stable; it
    // is consumed on every rising edge where oByte_valid && iByte_ready.
    assign pop = !fifo_empty && iByte_ready;

    always_ff @(posedge iClk) begin
        if (iRst) begin
            state        <= ST_IDLE;
            bit_count    <= '0;
            shift_q      <= '0;
            oFrame_done  <= 1'b0;
            oFrame_error <= 1'b0;
            oOverflow    <= 1'b0;
        end else begin
            state        <= state_nxt;
            bit_count    <= bit_count_nxt;
            shift_q      <= shift_nxt;
            oFrame_done  <= done_nxt;
            oFrame_error <= error_nxt;
            if (push && fifo_full && !pop) oOverflow <= 1'b1;
        end
    end

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (iClk),
        .rst     (iRst),
        .wr_en   (push),
        .wr_data (shift_inc),
        .rd_en   (iByte_ready),
        .rd_data (oByte),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign oByte_valid = !fifo_empty;
    assign oBit_count  = bit_count;

endmodule

// File: tb/tb_ciphertext_receiver.sv
// Directed bench for ciphertext_receiver: frame-level vector table plus
// hand-written restart, reset and idle-marker sequences.
module tb_ciphertext_receiver;

    localparam int MSG_SIZE   = 512;
    localparam int FIFO_DEPTH = 8;
    localparam int NEVER      = 1000000;

    logic        iClk = 1'b0;
    logic        iRst;
    logic        iSerial_in;
    logic        iSerial_start;
    logic        iSerial_end;
    logic [7:0]  oByte;
    logic        oByte_valid;
    logic        iByte_ready;
    logic        oFrame_done;
    logic        oFrame_error;
    logic        oOverflow;
    logic [9:0]  oBit_count;

    ciphertext_receiver #(
        .MSG_SIZE   (MSG_SIZE),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .iClk          (iClk),
        .iRst          (iRst),
        .iSerial_in    (iSerial_in),
        .iSerial_start (iSerial_start),
        .iSerial_end   (iSerial_end),
        .oByte         (oByte),
        .oByte_valid   (oByte_valid),
        .iByte_ready   (iByte_ready),
        .oFrame_done   (oFrame_done),
        .oFrame_error  (oFrame_error),
        .oOverflow     (oOverflow),
        .oBit_count    (oBit_count)
    );

    always #5 iClk = ~iClk;

    typedef struct {
        int         len;
        logic [7:0] pat;
        logic [7:0] inc;
        bit         use_end;
        int         ready_bit;
        bit         pre_rst;
        int         keep;
        int         exp_bytes;
        int         exp_done;
        int         exp_err;
        int         exp_cnt;
        bit         exp_ovf;
    } vec_t;

    logic [7:0] exp_q[$];
    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int err_cnt = 0;
    int byte_cnt = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // One clock: observe outputs at the falling edge, then let the rising edge happen.
    task automatic tick();
        @(negedge iClk);
        if (!iRst) begin
            if (oFrame_done) done_cnt++;
            if (oFrame_error) err_cnt++;
            if (oByte_valid && iByte_ready) begin
                byte_cnt++;
                if (exp_q.size() == 0) begin
                    check("unexpected_byte", int'(oByte), -1);
                end else begin
                    check("byte_data", int'(oByte), int'(exp_q.pop_front()));
                end
            end
        end
        @(posedge iClk);
        #1;
    endtask

    task automatic do_reset();
        iRst          = 1'b1;
        iSerial_in    = 1'b0;
        iSerial_start = 1'b0;
        iSerial_end   = 1'b0;
        iByte_ready   = 1'b0;
        tick();
        iRst = 1'b0;
        exp_q.delete();
    endtask

    task automatic send_frame(input int len, input logic [7:0] pat, input logic [7:0] inc,
                              input bit use_end, input int ready_bit, input int keep);
        logic [7:0] b;
        for (int i = 0; i < len; i++) begin
            b             = 8'(pat + inc * (i / 8));
            iSerial_in    = b[7 - (i % 8)];
            iSerial_start = (i == 0);
            iSerial_end   = use_end && (i == len - 1);
            iByte_ready   = (i >= ready_bit);
            if ((i % 8) == 7 && (i / 8) < keep) exp_q.push_back(b);
            tick();
        end
        iSerial_in    = 1'b0;
        iSerial_start = 1'b0;
        iSerial_end   = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        iByte_ready = 1'b1;
        tick();
        tick();
        while ((exp_q.size() != 0 || oByte_valid) && n < 200) begin
            tick();
            n++;
        end
        check("drain_timeout", int'(n >= 200), 0);
    endtask

    vec_t vecs[7];
    int   d0, e0, b0;

    initial begin
        vecs[0] = '{512, 8'hA5, 8'h00, 1'b1, 0,     1'b0, 64, 64, 1, 0, 512, 1'b0};
        vecs[1] = '{101, 8'h3C, 8'h00, 1'b1, 0,     1'b0, 64, 12, 0, 1, 101, 1'b0};
        vecs[2] = '{512, 8'h5A, 8'h01, 1'b0, 0,     1'b0, 64, 64, 0, 1, 512, 1'b0};
        vecs[3] = '{1,   8'h80, 8'h00, 1'b1, 0,     1'b0, 64, 0,  0, 1, 1,   1'b0};
        vecs[4] = '{8,   8'h96, 8'h00, 1'b1, 0,     1'b0, 64, 1,  0, 1, 8,   1'b0};
        vecs[5] = '{128, 8'h10, 8'h01, 1'b1, NEVER, 1'b1, 8,  8,  0, 1, 128, 1'b1};
        vecs[6] = '{72,  8'h20, 8'h01, 1'b1, 71,    1'b1, 64, 9,  0, 1, 72,  1'b0};

        iRst          = 1'b1;
        iSerial_in    = 1'b0;
        iSerial_start = 1'b0;
        iSerial_end   = 1'b0;
        iByte_ready   = 1'b0;
        tick();
        tick();
        check("rst_byte", int'(oByte), 0);
        check("rst_valid", int'(oByte_valid), 0);
        check("rst_done", int'(oFrame_done), 0);
        check("rst_error", int'(oFrame_error), 0);
        check("rst_overflow", int'(oOverflow), 0);
        check("rst_bit_count", int'(oBit_count), 0);
        iRst = 1'b0;
        tick();
        check("post_rst_valid", int'(oByte_valid), 0);
        check("post_rst_error", int'(oFrame_error), 0);

        foreach (vecs[v]) begin
            if (vecs[v].pre_rst) do_reset();
            d0 = done_cnt;
            e0 = err_cnt;
            b0 = byte_cnt;
            send_frame(vecs[v].len, vecs[v].pat, vecs[v].inc, vecs[v].use_end,
                       vecs[v].ready_bit, vecs[v].keep);
            if (exp_q.size() != 0) check($sformatf("v%0d_head", v), int'(oByte), int'(exp_q[0]));
            check($sformatf("v%0d_ovf", v), int'(oOverflow), int'(vecs[v].exp_ovf));
            wait_drain();
            check($sformatf("v%0d_bytes", v), byte_cnt - b0, vecs[v].exp_bytes);
            check($sformatf("v%0d_done", v), done_cnt - d0, vecs[v].exp_done);
            check($sformatf("v%0d_err", v), err_cnt - e0, vecs[v].exp_err);
            check($sformatf("v%0d_bit_count", v), int'(oBit_count), vecs[v].exp_cnt);
            check($sformatf("v%0d_ovf_sticky", v), int'(oOverflow), int'(vecs[v].exp_ovf));
        end

        // Second start after 40 bits: 5 bytes survive, new frame completes.
        do_reset();
        d0 = done_cnt; e0 = err_cnt; b0 = byte_cnt;
        send_frame(40, 8'h11, 8'h01, 1'b0, 0, 64);
        send_frame(512, 8'hC3, 8'h00, 1'b1, 0, 64);
        wait_drain();
        check("restart_bytes", byte_cnt - b0, 69);
        check("restart_err", err_cnt - e0, 1);
        check("restart_done", done_cnt - d0, 1);
        check("restart_bit_count", int'(oBit_count), 512);

        // Reset mid-frame at bit 200: FIFO flushed, no error pulse.
        d0 = done_cnt; e0 = err_cnt; b0 = byte_cnt;
        send_frame(200, 8'h40, 8'h01, 1'b0, 0, 64);
        iRst = 1'b1;
        tick();
        iRst = 1'b0;
        exp_q.delete();
        check("midrst_valid", int'(oByte_valid), 0);
        check("midrst_bit_count", int'(oBit_count), 0);
        tick();
        tick();
        check("midrst_err", err_cnt - e0, 0);
        check("midrst_bytes", byte_cnt - b0, 24);
        d0 = done_cnt; b0 = byte_cnt;
        send_frame(512, 8'hE1, 8'h00, 1'b1, 0, 64);
        wait_drain();
        check("after_rst_done", done_cnt - d0, 1);
        check("after_rst_bytes", byte_cnt - b0, 64);
        check("after_rst_err", err_cnt - e0, 0);

        // End marker in IDLE is ignored.
        d0 = done_cnt; e0 = err_cnt;
        iSerial_end = 1'b1;
        iSerial_in  = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        iSerial_end = 1'b0;
        iSerial_in  = 1'b0;
        wait_drain();
        check("idle_end_err", err_cnt - e0, 0);
        check("idle_end_done", done_cnt - d0, 0);
        check("idle_end_valid", int'(oByte_valid), 0);
        check("idle_end_bit_count", int'(oBit_count), 512);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ciphertext_receiver.md
CIPHERTEXT_RECEIVER -- requirements
Module: ciphertext_receiver

Interface
REQ-001 SHALL have parameter MSG_SIZE, default 512, frame length in bits, multiple of 8.
REQ-002 SHALL have parameter FIFO_DEPTH, default 8, byte FIFO entries, power of 2.
REQ-003 SHALL have port iClk, input, 1, the single clock; all logic on its rising edge.
REQ-004 SHALL have port iRst, input, 1; reset is synchronous and active-high.
REQ-005 SHALL have port iSerial_in, input, 1, ciphertext bit from the serialize stage.
REQ-006 SHALL have port iSerial_start, input, 1, first-bit marker of a frame.
REQ-007 SHALL have port iSerial_end, input, 1, last-bit marker of a frame.
REQ-008 SHALL have port oByte, output, 8, FIFO head byte.
REQ-009 SHALL have port oByte_valid, output, 1, FIFO non-empty.
REQ-010 SHALL have port iByte_ready, input, 1, consumer accepts head byte.
REQ-011 SHALL have port oFrame_done, output, 1, one-cycle pulse on a good frame.
REQ-012 SHALL have port oFrame_error, output, 1, one-cycle pulse on a framing fault.
REQ-013 SHALL have port oOverflow, output, 1, sticky FIFO-overflow flag.
REQ-014 SHALL have port oBit_count, output, $clog2(MSG_SIZE)+1, bits captured in current frame.

Function
REQ-015 SHALL sample iSerial_in every cycle from the iSerial_start cycle through the iSerial_end cycle inclusive.
REQ-016 SHALL implement FSM IDLE, RECV: IDLE->RECV on iSerial_start; RECV->IDLE on iSerial_end, bit-count limit, or fault.
REQ-017 SHALL shift bits MSB-first into an 8-bit register; the first frame bit becomes oByte[7].
REQ-018 SHALL push the assembled byte into the FIFO on the cycle its 8th bit is sampled; oByte_valid rises the following cycle.
REQ-019 SHALL pop the FIFO when oByte_valid and iByte_ready are both high; first-word-fall-through.
REQ-020 SHALL, when iSerial_end is sampled with oBit_count == MSG_SIZE-1, pulse oFrame_done the next cycle.
REQ-021 SHALL, when iSerial_end arrives early, pulse oFrame_error the next cycle, discard the partial byte and return to IDLE; whole bytes already pushed remain.
REQ-022 SHALL, when MSG_SIZE bits are sampled without iSerial_end, pulse oFrame_error and return to IDLE.
REQ-023 SHALL, when iSerial_start is sampled in RECV, pulse oFrame_error, discard the partial byte and restart at bit 0 with the current bit.
REQ-024 SHALL treat iSerial_start and iSerial_end together in IDLE as a 1-bit frame: oFrame_error pulse.
REQ-025 SHALL ignore iSerial_end in IDLE.
REQ-026 SHALL, on push while full with no simultaneous pop, drop the byte and set oOverflow until reset.
REQ-027 SHALL accept a push when full if a pop occurs in the same cycle.
REQ-028 SHALL hold oBit_count at its final value in IDLE and clear it to 1 on each frame start.

Reset
REQ-029 SHALL, on iRst high at a clock edge, enter IDLE, empty the FIFO, and clear shift register and oBit_count.
REQ-030 SHALL drive oByte=0, oByte_valid=0, oFrame_done=0, oFrame_error=0, oOverflow=0 during and after reset.
REQ-031 SHALL abandon any in-flight frame on reset without an oFrame_error pulse.

Structure
REQ-032 SHALL take the FSM state enum and the MSG_SIZE default from the shared package cipher_pkg.
REQ-033 SHALL instantiate one sub-module, sync_fifo (8-bit width, FIFO_DEPTH entries, FWFT, full/empty flags).

Verification
REQ-034 SHALL cover a 512-bit frame of 0xA5 repeated, iByte_ready=1: 64 bytes 0xA5 and one oFrame_done pulse.
REQ-035 SHALL cover iSerial_end at bit 100: oFrame_error pulse, 12 bytes output, partial bits discarded, no oFrame_done.
REQ-036 SHALL cover iByte_ready=0 for 16 bytes, FIFO_DEPTH=8: 8 bytes held, oOverflow=1, first byte intact.
REQ-037 SHALL cover a second iSerial_start at bit 40: oFrame_error pulse, 5 bytes kept, new frame completes with oFrame_done.
REQ-038 SHALL cover iRst asserted at bit 200: oByte_valid=0 next cycle, no oFrame_error, next frame received correctly.
REQ-039 SHALL cover full FIFO with iByte_ready=1 as the 8th bit of a new byte is sampled: byte accepted, oOverflow stays 0.
